// File: rtl/ser_req_arbiter.sv
// ser_req_arbiter
//   Shares one serializer between NREQ request queues. A pending request is
//   picked round-robin and popped from its queue. Its address is then handed
//   to the serializer. Aborted transfers (n_cs released early, reported as
//   err when ready_out returns) are retried up to MAX_RETRY times. Each
//   transaction ends with a one-cycle completion status pulse.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   en              grant enable (an in-flight transfer always completes)
//   req_valid       per-requester pending flag, held with req_addr until popped
//   req_addr        packed addresses, requester i at [i*ADDRW +: ADDRW]
//   req_pop         one-cycle one-hot pop strobe to the granted requester
//   ser_valid_in    load request to the serializer
//   ser_addr        address presented to the serializer
//   ser_ready_out   serializer idle / loaded indicator
//   ser_err         serializer abort flag, meaningful when ready_out rises
//   done_valid      one-cycle completion pulse
//   done_id         requester id of the completed transaction
//   done_ok         1 = delivered, 0 = failed after all attempts
//   done_tries      attempts used, valid with done_valid
//   busy            high whenever the arbiter is not idle
module ser_req_arbiter #(
    parameter int ADDRW     = 24,
    parameter int NREQ      = 4,
    parameter int MAX_RETRY = 3,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*ADDRW-1:0] req_addr,
    output logic [NREQ-1:0]       req_pop,
    output logic                  ser_valid_in,
    output logic [ADDRW-1:0]      ser_addr,
    input  logic                  ser_ready_out,
    input  logic                  ser_err,
    output logic                  done_valid,
    output logic [IDW-1:0]        done_id,
    output logic                  done_ok,
    output logic [3:0]            done_tries,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, REPORT} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   id_q, id_nxt;
    logic [IDW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [3:0]       retry_cnt, retry_nxt;
    logic [NREQ-1:0]  req_pop_nxt;
    logic             ser_valid_nxt;
    logic [ADDRW-1:0] ser_addr_nxt;
    logic             done_valid_nxt;
    logic [IDW-1:0]   done_id_nxt;
    logic             done_ok_nxt;
    logic [3:0]       done_tries_nxt;
    logic             busy_nxt;

    logic [IDW:0]     pick_res;
    logic             grant_found;
    logic [IDW-1:0]   grant_id;

    // First set bit at or above ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vec,
                                             input logic [IDW-1:0]  ptr);
        logic           found;
        logic [IDW-1:0] pick;
        int             idx;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && vec[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
        return {found, pick};
    endfunction

    assign pick_res    = rr_pick(req_valid, rr_ptr);
    assign grant_found = pick_res[IDW];
    assign grant_id    = pick_res[IDW-1:0];

    always_comb begin
        state_nxt      = state;
        id_nxt         = id_q;
        rr_ptr_nxt     = rr_ptr;
        retry_nxt      = retry_cnt;
        req_pop_nxt    = '0;
        ser_valid_nxt  = ser_valid_in;
        ser_addr_nxt   = ser_addr;
        done_valid_nxt = 1'b0;
        done_id_nxt    = done_id;
        done_ok_nxt    = done_ok;
        done_tries_nxt = done_tries;
        busy_nxt       = busy;

        case (state)
            IDLE: begin
                // req_valid is only looked at here; ser_addr doubles as the
                // latched address for every retry of this transaction.
                if (en && grant_found) begin
                    id_nxt        = grant_id;
                    ser_addr_nxt  = req_addr[int'(grant_id)*ADDRW +: ADDRW];
                    retry_nxt     = 4'd0;
                    req_pop_nxt   = NREQ'(1) << grant_id;
                    ser_valid_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                // ready_out falling means the serializer took the address;
                // ser_err here is left over from an earlier abort.
                if (!ser_ready_out) begin
                    ser_valid_nxt = 1'b0;
                    state_nxt     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (ser_ready_out) begin
                    if (!ser_err) begin
                        done_ok_nxt    = 1'b1;
                        done_valid_nxt = 1'b1;
                        done_id_nxt    = id_q;
                        done_tries_nxt = retry_cnt + 4'd1;
                        state_nxt      = REPORT;
                    end else if (retry_cnt < 4'(MAX_RETRY)) begin
                        retry_nxt     = retry_cnt + 4'd1;
                        ser_valid_nxt = 1'b1;
                        state_nxt     = ISSUE;
                    end else begin
                        done_ok_nxt    = 1'b0;
                        done_valid_nxt = 1'b1;
                        done_id_nxt    = id_q;
                        done_tries_nxt = retry_cnt + 4'd1;
                        state_nxt      = REPORT;
                    end
                end
            end
            REPORT: begin
                // done_valid is high during this state; the pointer moves past
                // the requester just served so it waits at most NREQ-1 grants.
                rr_ptr_nxt = IDW'((int'(id_q) + 1) % NREQ);
                busy_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            id_q         <= '0;
            rr_ptr       <= '0;
            retry_cnt    <= 4'd0;
            req_pop      <= '0;
            ser_valid_in <= 1'b0;
            ser_addr     <= '0;
            done_valid   <= 1'b0;
            done_id      <= '0;
            done_ok      <= 1'b0;
            done_tries   <= 4'd0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            id_q         <= id_nxt;
            rr_ptr       <= rr_ptr_nxt;
            retry_cnt    <= retry_nxt;
            req_pop      <= req_pop_nxt;
            ser_valid_in <= ser_valid_nxt;
            ser_addr     <= ser_addr_nxt;
            done_valid   <= done_valid_nxt;
            done_id      <= done_id_nxt;
            done_ok      <= done_ok_nxt;
            done_tries   <= done_tries_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_ser_req_arbiter.sv
// tb_ser_req_arbiter
//   Randomised bench for ser_req_arbiter with a behavioural serializer, a
//   requester driver and a scoreboard monitor that predicts grants
//   round-robin and completion status from the planned abort count.
module tb_ser_req_arbiter;

    localparam int ADDRW     = 24;
    localparam int NREQ      = 4;
    localparam int MAX_RETRY = 3;
    localparam int IDW       = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  en = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*ADDRW-1:0] req_addr = '0;
    logic [NREQ-1:0]       req_pop;
    logic                  ser_valid_in;
    logic [ADDRW-1:0]      ser_addr;
    logic                  ser_ready_out = 1'b1;
    logic                  ser_err = 1'b0;
    logic                  done_valid;
    logic [IDW-1:0]        done_id;
    logic                  done_ok;
    logic [3:0]            done_tries;
    logic                  busy;

    ser_req_arbiter #(.ADDRW(ADDRW), .NREQ(NREQ), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_addr(req_addr), .req_pop(req_pop),
        .ser_valid_in(ser_valid_in), .ser_addr(ser_addr),
        .ser_ready_out(ser_ready_out), .ser_err(ser_err),
        .done_valid(done_valid), .done_id(done_id), .done_ok(done_ok),
        .done_tries(done_tries), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               id;
        logic [ADDRW-1:0] addr;
        bit               ok;
        int               tries;
    } exp_t;

    exp_t sb_q[$];
    int   grant_log[$];
    int   checks = 0;
    int   failures = 0;

    // shared between driver, monitor and serializer model
    int   pend[NREQ];
    bit   cont_mode = 1'b0;
    bit   rand_en = 1'b0;
    int   force_aborts = 0;
    int   plan_left = 0;
    int   exp_ptr = 0;
    bit   in_flight = 1'b0;
    int   ser_ph = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic bit all_done();
        int s;
        s = 0;
        for (int i = 0; i < NREQ; i++) s += pend[i];
        return (s == 0) && !in_flight && (req_valid == '0) && (sb_q.size() == 0);
    endfunction

    // Serializer: loads 0..2 cycles after valid_in, busy 2..6 cycles, then
    // returns ready with err set while planned aborts remain. err is left
    // stale between transfers.
    int ld_wait = 0;
    int busy_cnt = 0;
    initial begin
        forever begin
            @(posedge clk); #2;
            if (!rst_n) begin
                ser_ready_out = 1'b1;
                ser_err       = 1'b0;
                ser_ph        = 0;
                ld_wait       = 0;
                plan_left     = 0;
            end else if (ser_ph == 0) begin
                if (ser_valid_in) begin
                    if (ld_wait == 0) begin
                        ser_ready_out = 1'b0;
                        ser_ph        = 1;
                        busy_cnt      = $urandom_range(1, 5);
                    end else begin
                        ld_wait--;
                    end
                end else begin
                    ld_wait = $urandom_range(0, 2);
                end
            end else begin
                if (busy_cnt == 0) begin
                    ser_ready_out = 1'b1;
                    ser_err       = (plan_left > 0);
                    if (plan_left > 0) plan_left--;
                    ser_ph  = 0;
                    ld_wait = $urandom_range(0, 2);
                end else begin
                    busy_cnt--;
                end
            end
        end
    end

    // Monitor / scoreboard
    exp_t cur;
    exp_t got;
    int   loads = 0;
    int   exp_id = 0;
    int   plan = 0;
    bit   exp_pop = 1'b0;
    bit   was_idle = 1'b1;
    bit   prev_valid = 1'b0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                check("reset_outputs",
                      64'({req_pop, ser_valid_in, ser_addr, done_valid, done_id, done_ok, done_tries, busy}),
                      64'(0));
                sb_q.delete();
                in_flight  = 1'b0;
                was_idle   = 1'b1;
                prev_valid = 1'b0;
                exp_ptr    = 0;
                continue;
            end
            exp_pop = was_idle && en && (req_valid != '0);
            check("pop_present", 64'(req_pop != '0), 64'(exp_pop));
            if (exp_pop && req_pop != '0) begin
                exp_id = ref_pick(req_valid, exp_ptr);
                check("pop_id", 64'(req_pop), 64'(1) << exp_id);
                plan = (force_aborts >= 0) ? force_aborts : $urandom_range(0, 5);
                plan_left = plan;
                cur.id    = exp_id;
                cur.addr  = req_addr[exp_id*ADDRW +: ADDRW];
                cur.ok    = (plan <= MAX_RETRY);
                cur.tries = ((plan > MAX_RETRY) ? MAX_RETRY : plan) + 1;
                sb_q.push_back(cur);
                grant_log.push_back(exp_id);
                in_flight = 1'b1;
                loads     = 0;
            end
            check("busy", 64'(busy), 64'(in_flight));
            was_idle = !in_flight;
            if (prev_valid && !ser_valid_in) loads++;
            prev_valid = ser_valid_in;
            if (ser_valid_in) begin
                check("valid_in_txn", 64'(in_flight), 64'(1));
                check("ser_addr", 64'(ser_addr), 64'(cur.addr));
            end
            if (done_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected: got done_valid=1 expected no outstanding txn at %0t", $time);
                end else begin
                    got = sb_q.pop_front();
                    check("done_id", 64'(done_id), 64'(got.id));
                    check("done_ok", 64'(done_ok), 64'(got.ok));
                    check("done_tries", 64'(done_tries), 64'(got.tries));
                    check("load_count", 64'(loads), 64'(got.tries));
                    exp_ptr = (got.id + 1) % NREQ;
                end
                in_flight = 1'b0;
            end
        end
    end

    // Requester driver
    task automatic new_addr(input int i);
        req_addr[i*ADDRW +: ADDRW] = ADDRW'($urandom);
    endtask

    task automatic step();
        @(posedge clk); #2;
        for (int i = 0; i < NREQ; i++) begin
            if (rst_n && req_pop[i]) begin
                pend[i]--;
                if (pend[i] > 0 && cont_mode) new_addr(i);
                else req_valid[i] = 1'b0;
            end else if (!req_valid[i] && pend[i] > 0 &&
                         (cont_mode || $urandom_range(0, 3) == 0)) begin
                req_valid[i] = 1'b1;
                new_addr(i);
            end
        end
        if (rand_en) en = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !all_done()) begin
            step();
            n++;
        end
        check(name, 64'(all_done()), 64'(1));
    endtask

    task automatic present(input int i, input logic [ADDRW-1:0] a);
        pend[i] = 1;
        req_valid[i] = 1'b1;
        req_addr[i*ADDRW +: ADDRW] = a;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        repeat (3) @(posedge clk);
        @(posedge clk); #4;
        rst_n = 1'b1;

        // enable gating: everything pending, no grant until en rises
        for (int i = 0; i < NREQ; i++) present(i, ADDRW'($urandom));
        repeat (50) step();
        check("gate_busy", 64'(busy), 64'(0));
        check("gate_no_pop", 64'(grant_log.size()), 64'(0));
        en = 1'b1;
        step();
        check("en_first_grant", 64'(req_pop), 64'(4'b0001));
        drain("gate_drain", 400);

        // round-robin with all requesters continuously pending
        grant_log.delete();
        force_aborts = 0;
        cont_mode = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 3;
            req_valid[i] = 1'b1;
            new_addr(i);
        end
        drain("rr_drain", 1500);
        cont_mode = 1'b0;
        check("rr_count", 64'(grant_log.size()), 64'(12));
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            check("rr_order", 64'(grant_log[k]), 64'(k % NREQ));
        for (int s = 0; s + 3 < grant_log.size(); s++)
            for (int a = 0; a < 4; a++)
                for (int b = a + 1; b < 4; b++)
                    check("rr_window_distinct", 64'(grant_log[s+a] != grant_log[s+b]), 64'(1));

        // single clean request from requester 2
        grant_log.delete();
        present(2, 24'hABCDEF);
        drain("single_drain", 400);
        check("single_grants", 64'(grant_log.size()), 64'(1));

        // one abort then success
        grant_log.delete();
        force_aborts = 1;
        present(1, ADDRW'($urandom));
        drain("retry_drain", 400);
        check("retry_single_pop", 64'(grant_log.size()), 64'(1));

        // every attempt aborted
        force_aborts = MAX_RETRY + 3;
        present(3, ADDRW'($urandom));
        drain("exhaust_drain", 600);

        // random traffic, random enable, random abort counts
        force_aborts = -1;
        rand_en = 1'b1;
        for (int i = 0; i < NREQ; i++) pend[i] = $urandom_range(3, 8);
        drain("random_phase", 8000);
        rand_en = 1'b0;
        en = 1'b1;
        drain("random_drain", 4000);

        // reset while the serializer holds a transfer
        force_aborts = 0;
        present(1, ADDRW'($urandom));
        begin
            int n;
            n = 0;
            while (n < 200 && ser_ph != 1) begin
                step();
                #1;
                n++;
            end
        end
        check("reach_wait_done", 64'(ser_ph), 64'(1));
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({req_pop, ser_valid_in, ser_addr, done_valid, done_id, done_ok, done_tries, busy}),
              64'(0));
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        req_valid = '0;
        repeat (3) @(posedge clk);
        @(posedge clk); #4;
        rst_n = 1'b1;
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) present(i, ADDRW'($urandom));
        drain("post_reset_drain", 1000);
        check("post_reset_grants", 64'(grant_log.size()), 64'(NREQ));
        if (grant_log.size() > 0)
            check("post_reset_first", 64'(grant_log[0]), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
